// File: rtl/div_nnbit_restoring.sv
// rtl/div_nnbit_restoring.sv - iterative restoring divider, signed/unsigned, one quotient bit per clock
module div_nnbit_restoring #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_sign,
    input  logic [DATA_WIDTH-1:0] i_num_x,
    input  logic [DATA_WIDTH-1:0] i_num_y,
    output logic                  o_busy,
    output logic                  o_end,
    output logic [DATA_WIDTH-1:0] o_quo,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic                  o_err
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Captured operands and mode
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic             signed_q, signed_d;

    // Iteration state: partial remainder R (W+1 bits), quotient/dividend shifter Q, |y|
    logic [W:0]       r_q, r_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     mag_y_q, mag_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    // Architectural results, held between operations
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             err_q, err_d;

    // Magnitudes of the captured operands; the most-negative value maps onto 2^(W-1)
    logic             x_neg;
    logic             y_neg;
    logic [W-1:0]     mag_x;
    logic [W-1:0]     mag_y;

    // One restoring step: shift {R,Q} left and trial-subtract |y| with a spare sign bit
    logic [W+1:0]     r_shift;
    logic [W+1:0]     diff;
    logic             diff_neg;

    // Operand sign handling and the trial subtraction for the current iteration
    always_comb begin
        x_neg    = signed_q & x_q[W-1];
        y_neg    = signed_q & y_q[W-1];
        mag_x    = x_neg ? -x_q : x_q;
        mag_y    = y_neg ? -y_q : y_q;
        r_shift  = {r_q, q_q[W-1]};
        diff     = r_shift - {2'b00, mag_y_q};
        diff_neg = diff[W+1];
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                state_d = (y_q == '0) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        o_busy = (state_q != ST_IDLE);
        o_end  = (state_q == ST_DONE);
    end

    // Datapath next values for operands, iteration registers and results
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        signed_d  = signed_q;
        r_d       = r_q;
        q_d       = q_q;
        mag_y_d   = mag_y_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    x_d      = i_num_x;
                    y_d      = i_num_y;
                    signed_d = i_sign;
                    err_d    = 1'b0;
                end
            end
            ST_PREP: begin
                if (y_q == '0) begin
                    // Divide by zero: all-ones quotient, raw dividend as remainder
                    quo_d = '1;
                    rem_d = x_q;
                    err_d = 1'b1;
                end else begin
                    neg_quo_d = x_neg ^ y_neg;
                    neg_rem_d = x_neg;
                    r_d       = '0;
                    q_d       = mag_x;
                    mag_y_d   = mag_y;
                    cnt_d     = '0;
                end
            end
            ST_CALC: begin
                // Keep the difference when it did not go negative, else restore the shifted R
                r_d   = diff_neg ? r_shift[W:0] : diff[W:0];
                q_d   = {q_q[W-2:0], ~diff_neg};
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_FIX: begin
                // Truncating division: quotient sign from both operands, remainder follows dividend
                quo_d = neg_quo_q ? -q_q : q_q;
                rem_d = neg_rem_q ? -r_q[W-1:0] : r_q[W-1:0];
            end
            default: begin
            end
        endcase
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            signed_q  <= 1'b0;
            r_q       <= '0;
            q_q       <= '0;
            mag_y_q   <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            signed_q  <= signed_d;
            r_q       <= r_d;
            q_q       <= q_d;
            mag_y_q   <= mag_y_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
        end
    end

    assign o_quo = quo_q;
    assign o_rem = rem_q;
    assign o_err = err_q;

endmodule

// File: tb/tb_div_nnbit_restoring.sv
// tb/tb_div_nnbit_restoring.sv - self-checking bench for div_nnbit_restoring
module tb_div_nnbit_restoring;

    localparam int W = 16;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_start;
    logic         i_sign;
    logic [W-1:0] i_num_x;
    logic [W-1:0] i_num_y;
    logic         o_busy;
    logic         o_end;
    logic [W-1:0] o_quo;
    logic [W-1:0] o_rem;
    logic         o_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    div_nnbit_restoring #(.DATA_WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_sign  (i_sign),
        .i_num_x (i_num_x),
        .i_num_y (i_num_y),
        .o_busy  (o_busy),
        .o_end   (o_end),
        .o_quo   (o_quo),
        .o_rem   (o_rem),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    // Reference: plain integer arithmetic, C-style truncating division
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
        int xi;
        int yi;
        if (y == '0) begin
            q = '1;
            r = x;
            e = 1'b1;
        end else begin
            if (s) begin
                xi = int'($signed(x));
                yi = int'($signed(y));
            end else begin
                xi = int'(x);
                yi = int'(y);
            end
            q = W'(xi / yi);
            r = W'(xi % yi);
            e = 1'b0;
        end
    endfunction

    // Drives one start and watches until o_end (bounded); lat=0 means it never came
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic e,
                          output int lat, output int busy_n);
        q = 'x;
        r = 'x;
        e = 1'bx;
        lat = 0;
        busy_n = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_num_x = x;
        i_num_y = y;
        i_sign  = s;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_num_x = W'($urandom);
        i_num_y = W'($urandom);
        i_sign  = 1'($urandom);
        for (int n = 1; n <= 60; n++) begin
            @(negedge i_clk);
            if (o_busy) busy_n++;
            if (o_end) begin
                lat = n;
                q = o_quo;
                r = o_rem;
                e = o_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_sign  = 1'b0;
        i_num_x = '0;
        i_num_y = '0;
        #12;
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
        total_cnt++; if (o_end !== 1'b0) $display("FAIL reset_end: got %b want 0", o_end); else pass_cnt++;
        total_cnt++; if (o_quo !== 16'h0000) $display("FAIL reset_quo: got %h want 0000", o_quo); else pass_cnt++;
        total_cnt++; if (o_rem !== 16'h0000) $display("FAIL reset_rem: got %h want 0000", o_rem); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0) $display("FAIL reset_err: got %b want 0", o_err); else pass_cnt++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           lat;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[8];
        logic [W-1:0] q, r;
        logic e;
        int lat, busy_n;
        tbl[0] = '{16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 19};
        tbl[1] = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 19};
        tbl[2] = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 19};
        tbl[3] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 19};
        tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 19};
        tbl[5] = '{16'h0000, 16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0, 19};
        tbl[6] = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 2};
        tbl[7] = '{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 2};
        foreach (tbl[i]) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].s, q, r, e, lat, busy_n);
            total_cnt++; if (q !== tbl[i].q) $display("FAIL dir%0d_quo: got %h want %h", i, q, tbl[i].q); else pass_cnt++;
            total_cnt++; if (r !== tbl[i].r) $display("FAIL dir%0d_rem: got %h want %h", i, r, tbl[i].r); else pass_cnt++;
            total_cnt++; if (e !== tbl[i].e) $display("FAIL dir%0d_err: got %b want %b", i, e, tbl[i].e); else pass_cnt++;
            total_cnt++; if (lat != tbl[i].lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].lat); else pass_cnt++;
            total_cnt++; if (busy_n != tbl[i].lat) $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, busy_n, tbl[i].lat); else pass_cnt++;
        end
    endtask

    task automatic test_div_zero_clear();
        logic [W-1:0] q, r;
        logic e;
        int lat, busy_n;
        run_op(16'h1234, 16'h0000, 1'b1, q, r, e, lat, busy_n);
        total_cnt++; if (e !== 1'b1) $display("FAIL dz_err_set: got %b want 1", e); else pass_cnt++;
        @(negedge i_clk);
        total_cnt++; if (o_err !== 1'b1) $display("FAIL dz_err_held: got %b want 1", o_err); else pass_cnt++;
        total_cnt++; if (o_quo !== 16'hFFFF) $display("FAIL dz_quo_held: got %h want ffff", o_quo); else pass_cnt++;
        run_op(16'h0009, 16'h0003, 1'b0, q, r, e, lat, busy_n);
        total_cnt++; if (e !== 1'b0) $display("FAIL dz_err_cleared: got %b want 0", e); else pass_cnt++;
        total_cnt++; if (q !== 16'h0003) $display("FAIL dz_next_quo: got %h want 0003", q); else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        int ends, lat;
        logic [W-1:0] q, r;
        ends = 0;
        lat = 0;
        q = 'x;
        r = 'x;
        @(negedge i_clk);
        i_start = 1'b1;
        i_num_x = 16'h00C8;
        i_num_y = 16'h000A;
        i_sign  = 1'b0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge i_clk);
            if (n == 4) begin
                i_start = 1'b1;
                i_num_x = 16'h0001;
                i_num_y = 16'h0001;
            end else begin
                i_start = 1'b0;
            end
            if (o_end) begin
                ends++;
                if (lat == 0) begin
                    lat = n;
                    q = o_quo;
                    r = o_rem;
                end
            end
        end
        total_cnt++; if (ends != 1) $display("FAIL busy_end_pulses: got %0d want 1", ends); else pass_cnt++;
        total_cnt++; if (lat != 19) $display("FAIL busy_latency: got %0d want 19", lat); else pass_cnt++;
        total_cnt++; if (q !== 16'h0014) $display("FAIL busy_quo: got %h want 0014", q); else pass_cnt++;
        total_cnt++; if (r !== 16'h0000) $display("FAIL busy_rem: got %h want 0000", r); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL busy_idle_after: got %b want 0", o_busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r;
        logic e;
        int lat, busy_n;
        run_op(16'h0100, 16'h0010, 1'b0, q, r, e, lat, busy_n);
        total_cnt++; if (q !== 16'h0010) $display("FAIL b2b_first_quo: got %h want 0010", q); else pass_cnt++;
        // next run_op starts on the very next negedge: start high in the cycle after DONE
        run_op(16'hFF9C, 16'h0007, 1'b1, q, r, e, lat, busy_n);
        total_cnt++; if (lat != 19) $display("FAIL b2b_latency: got %0d want 19", lat); else pass_cnt++;
        total_cnt++; if (q !== 16'hFFF2) $display("FAIL b2b_quo: got %h want fff2", q); else pass_cnt++;
        total_cnt++; if (r !== 16'hFFFE) $display("FAIL b2b_rem: got %h want fffe", r); else pass_cnt++;
        repeat (3) @(negedge i_clk);
        total_cnt++; if (o_quo !== 16'hFFF2) $display("FAIL b2b_quo_held: got %h want fff2", o_quo); else pass_cnt++;
        total_cnt++; if (o_end !== 1'b0) $display("FAIL b2b_end_low: got %b want 0", o_end); else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        logic [W-1:0] q, r;
        logic e;
        int lat, busy_n;
        @(negedge i_clk);
        i_start = 1'b1;
        i_num_x = 16'h4321;
        i_num_y = 16'h0007;
        i_sign  = 1'b0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (8) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", o_busy); else pass_cnt++;
        total_cnt++; if (o_end !== 1'b0) $display("FAIL rst_mid_end: got %b want 0", o_end); else pass_cnt++;
        total_cnt++; if (o_quo !== 16'h0000) $display("FAIL rst_mid_quo: got %h want 0000", o_quo); else pass_cnt++;
        total_cnt++; if (o_rem !== 16'h0000) $display("FAIL rst_mid_rem: got %h want 0000", o_rem); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", o_err); else pass_cnt++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op(16'd1000, 16'd3, 1'b0, q, r, e, lat, busy_n);
        total_cnt++; if (q !== 16'h014D) $display("FAIL rst_after_quo: got %h want 014d", q); else pass_cnt++;
        total_cnt++; if (r !== 16'h0001) $display("FAIL rst_after_rem: got %h want 0001", r); else pass_cnt++;
        total_cnt++; if (lat != 19) $display("FAIL rst_after_latency: got %0d want 19", lat); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, q, r, eq, er;
        logic s, e, ee;
        int lat, busy_n, sel, elat;
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            x = W'($urandom);
            s = 1'($urandom);
            case (sel)
                0:       y = '0;
                1:       y = 16'hFFFF;
                2:       y = W'($urandom_range(1, 15));
                3:       begin x = 16'h8000; y = W'($urandom); end
                4:       begin x = '0; y = W'($urandom_range(1, 65535)); end
                default: y = W'($urandom);
            endcase
            model(x, y, s, eq, er, ee);
            elat = (y == '0) ? 2 : W + 3;
            run_op(x, y, s, q, r, e, lat, busy_n);
            total_cnt++; if (q !== eq) $display("FAIL rnd%0d_quo: x=%h y=%h s=%b got %h want %h", i, x, y, s, q, eq); else pass_cnt++;
            total_cnt++; if (r !== er) $display("FAIL rnd%0d_rem: x=%h y=%h s=%b got %h want %h", i, x, y, s, r, er); else pass_cnt++;
            total_cnt++; if (e !== ee) $display("FAIL rnd%0d_err: x=%h y=%h got %b want %b", i, x, y, e, ee); else pass_cnt++;
            total_cnt++; if (lat != elat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero_clear();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/div_nnbit_restoring.md
Name: div_nnbit_restoring

Overview:
- Iterative restoring integer divider. It is the inverse operation of the multiplier path in the calc library.
- Accepts dividend/divisor on a start pulse and produces one quotient bit per clock.
- Supports signed (two's complement) and unsigned operands, plus divide-by-zero and signed-overflow cases.
- Sits beside the mul blocks in src/calc and is intended as the DIV/REM unit of the execute stage.

Parameters:
- DATA_WIDTH, 16, operand/quotient/remainder width in bits; legal values are 4 to 64.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  reset; asynchronous assert, active-low.
- i_start  input  1  start request; sampled only in IDLE.
- i_sign  input  1  1 = signed division, 0 = unsigned; captured with i_start.
- i_num_x  input  DATA_WIDTH  dividend; captured with i_start.
- i_num_y  input  DATA_WIDTH  divisor; captured with i_start.
- o_busy  output  1  high whenever state != IDLE.
- o_end  output  1  one-cycle pulse; result valid.
- o_quo  output  DATA_WIDTH  quotient; held until next accepted start.
- o_rem  output  DATA_WIDTH  remainder; held until next accepted start.
- o_err  output  1  divide-by-zero flag; held with result.

Behaviour:
- Reset:
  - Clock and reset are one clock i_clk with asynchronous active-low reset i_rst_n.
  - Asserting i_rst_n low at any time, including mid-CALC, forces state IDLE.
  - o_busy=0, o_end=0, o_quo=0, o_rem=0, o_err=0, and all internal registers are cleared.
  - Any operation in flight is discarded.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - If i_start=1, register x, y and i_sign, clear o_err, go to PREP.
  - Otherwise stay in IDLE.
- PREP (1 cycle):
  - If y==0: o_quo=all ones, o_rem=x (raw, unmodified), o_err=1, go to DONE.
  - Otherwise: if signed, take |x| and |y| as DATA_WIDTH-bit unsigned magnitudes. The most-negative value maps to 2^(W-1) unsigned.
  - Record sign_q = x[W-1]^y[W-1] and sign_r = x[W-1] (both 0 when unsigned).
  - Load partial remainder R = 0 (W+1 bits), Q = |x|, counter = 0, go to CALC.
- CALC (exactly DATA_WIDTH cycles):
  - Each cycle: shift {R,Q} left by 1, compute T = R - {1'b0,|y|}.
  - If T is non-negative, R = T and Q[0] = 1; else R is restored and Q[0] = 0.
  - Counter increments; after iteration W-1, go to FIX.
- FIX (1 cycle):
  - o_quo = sign_q ? -Q : Q.
  - o_rem = sign_r ? -R[W-1:0] : R[W-1:0].
  - Go to DONE.
- DONE (1 cycle): o_end=1, go to IDLE. Result registers are not modified.
- Latency, with the start sampled at edge k:
  - Normal operation: o_end is high in cycle k+DATA_WIDTH+3 (k+19 at default).
  - Divide-by-zero: o_end is high in cycle k+2.
- o_busy is high from cycle k+1 through the DONE cycle inclusive. The next start is accepted in the cycle after DONE.
- i_start while o_busy=1 is ignored, with no effect on the operation in flight. Operand inputs are not required to be stable after the start cycle.
- Signed overflow (x = most negative, y = -1, signed) needs no special path:
  - The result falls out as o_quo = 2^(W-1) pattern (0x8000), o_rem = 0, o_err = 0.
- Remainder sign follows the dividend, quotient truncates toward zero (C/RISC-V semantics).
- x=0 with y!=0 gives quo=0, rem=0 with normal latency.

Test Plan:
- Unsigned 100/7 (i_sign=0, x=0x0064, y=0x0007): o_quo=0x000E, o_rem=0x0002, o_err=0; o_end exactly 19 cycles after the start edge; o_busy high for 19 cycles.
- Signed -7/2 (x=0xFFF9, y=0x0002): o_quo=0xFFFD, o_rem=0xFFFF. Signed 7/-2 (x=0x0007, y=0xFFFE): o_quo=0xFFFD, o_rem=0x0001.
- Divide by zero (x=0x1234, y=0x0000, either sign mode): o_quo=0xFFFF, o_rem=0x1234, o_err=1; o_end 2 cycles after start. A following valid start clears o_err.
- Signed overflow (x=0x8000, y=0xFFFF, i_sign=1): o_quo=0x8000, o_rem=0x0000, o_err=0. Unsigned 0xFFFF/0x0001: o_quo=0xFFFF, o_rem=0.
- Start while busy: start 0x00C8/0x000A, then pulse i_start with 0x0001/0x0001 at cycle 5. The result is still quo=0x0014, rem=0, with a single o_end pulse. Back-to-back start in the cycle after DONE is accepted.
- Reset mid-CALC (drop i_rst_n at cycle 8, asynchronously): all outputs go to 0 immediately and o_busy=0. After release, a new 1000/3 completes with quo=0x014D, rem=0x0001.
